uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_arb_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default requester count for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

    localparam int UART_NREQ_DEFAULT = 4;

endpackage

// File: rtl/uart_arb_pick.sv
// uart_arb_pick: combinational winner pick over a request vector, searching upward from a start index
//   req    : per-requester valid bits
//   start  : index that has highest priority (wraps modulo NREQ)
//   winner : first valid index at or after start
//   any    : at least one request is valid
module uart_arb_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] start,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    any
);

    localparam int W = $clog2(NREQ);

    // Walk offsets from farthest to nearest so the nearest valid index overwrites last.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(start) + i) % NREQ]) winner = W'((int'(start) + i) % NREQ);
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates NREQ byte sources onto a single uart_tx write port
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester byte pending
//   req_data   : per-requester byte, requester i on bits [8i+7:8i]
//   req_ack    : one-cycle one-hot pulse when a requester's byte is taken by uart_tx
//   tx_data    : latched byte for uart_tx
//   tx_wr_en   : uart_tx write enable, high while in LOAD
//   tx_rdy     : uart_tx idle flag
//   busy       : high whenever not IDLE
//   grant_id   : index of the current or last winner
// Define UART_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ = UART_NREQ_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ack,
    output logic [7:0]              tx_data,
    output logic                    tx_wr_en,
    input  logic                    tx_rdy,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int W = $clog2(NREQ);

    state_t       state, next_state;
    logic [W-1:0] start, winner;
    logic         any, sel, fire;

    uart_arb_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_valid),
        .start  (start),
        .winner (winner),
        .any    (any)
    );

`ifdef UART_ARB_RR_EN
    logic [W-1:0] ptr;

    // The requester after the one just accepted gets first look next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (fire) ptr <= (grant_id == W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        sel        = 1'b0;
        fire       = 1'b0;
        tx_wr_en   = 1'b0;
        busy       = state != IDLE;
        case (state)
            IDLE: begin
                sel        = any && tx_rdy;
                next_state = sel ? LOAD : IDLE;
            end
            LOAD: begin
                tx_wr_en   = 1'b1;
                fire       = !tx_rdy;
                next_state = fire ? BUSY : LOAD;
            end
            BUSY:    next_state = tx_rdy ? IDLE : BUSY;
            default: next_state = IDLE;
        endcase
    end

    // The byte is captured at selection so later req_data/req_valid changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            grant_id <= '0;
            req_ack  <= '0;
        end else begin
            req_ack <= fire ? NREQ'(1) << grant_id : '0;
            if (sel) begin
                tx_data  <= req_data[8*int'(winner) +: 8];
                grant_id <= winner;
            end
        end
    end

endmodule
